// File: rtl/rca_pipe_if.sv
// Stream bundle for rca_pipe_adder: operand/carry-in handshake in, sum/carry-out handshake out.
// The ovf signal exists only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef RCA_PIPE_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef RCA_PIPE_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per register stage, whole pipe
// advances together on a single enable. Optional signed-overflow output: RCA_PIPE_OVF_EN.
module rca_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic        clk,
  input logic        rst_n,
  rca_pipe_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic                           en;
  logic [STAGES-1:0]              vld_q, vld_in;
  logic [STAGES-1:0]              cry_q, cry_in, cry_d;
  logic [STAGES-1:0][WIDTH-1:0]   opa_q, opb_q, sum_q;
  logic [STAGES-1:0][WIDTH-1:0]   opa_in, opb_in, sum_in, sum_d;

  assign en           = !vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   tot;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_first
      assign vld_in[k] = bus.in_valid;
      assign cry_in[k] = bus.cin;
      assign opa_in[k] = bus.a;
      assign opb_in[k] = bus.b;
      assign sum_in[k] = '0;
    end else begin : g_next
      assign vld_in[k] = vld_q[k-1];
      assign cry_in[k] = cry_q[k-1];
      assign opa_in[k] = opa_q[k-1];
      assign opb_in[k] = opb_q[k-1];
      assign sum_in[k] = sum_q[k-1];
    end

    assign tot = {1'b0, opa_in[k][k*CHUNK +: CHUNK]}
               + {1'b0, opb_in[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cry_in[k]};

    // Lower chunks pass through from the previous stage; this stage fills chunk k.
    always_comb begin
      merged                    = sum_in[k];
      merged[k*CHUNK +: CHUNK]  = tot[CHUNK-1:0];
    end

    assign sum_d[k] = merged;
    assign cry_d[k] = tot[CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cry_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      sum_q <= '0;
    end else if (en) begin
      vld_q <= vld_in;
      cry_q <= cry_d;
      opa_q <= opa_in;
      opb_q <= opb_in;
      sum_q <= sum_d;
    end
  end

  // Operand chunks already consumed by earlier slices are never read again.
  logic unused_opnd;
  assign unused_opnd = ^{opa_q, opb_q};

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = cry_q[STAGES-1];

`ifdef RCA_PIPE_OVF_EN
  logic msb_cin, ovf_d, ovf_q;

  assign msb_cin = opa_in[STAGES-1][WIDTH-1] ^ opb_in[STAGES-1][WIDTH-1]
                 ^ sum_d[STAGES-1][WIDTH-1];
  assign ovf_d   = msb_cin ^ cry_d[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca_pipe_adder.sv
// Bench for rca_pipe_adder (16-bit/4-bit slices, plus an 8-bit single-stage instance).
module tb_rca_pipe_adder;
  localparam int W = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(W)) bus ();
  rca_pipe_if #(.WIDTH(8)) bus8 ();

  rca_pipe_adder #(.WIDTH(W), .CHUNK(C)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  rca_pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0]   exp_q[$];
  logic         s_rdy, s_ov, s_cout, in_fire, out_fire;
  logic [W-1:0] s_sum;
`ifdef RCA_PIPE_OVF_EN
  logic         s_ovf;
`endif

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {8'b0, ci};
  endfunction

  // One clock: drive at posedge+1, sample at negedge, record accepted inputs in the model.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic ordy);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.cin       = ic;
    bus.out_ready = ordy;
    @(negedge clk);
    s_rdy  = bus.in_ready;
    s_ov   = bus.out_valid;
    s_sum  = bus.sum;
    s_cout = bus.cout;
`ifdef RCA_PIPE_OVF_EN
    s_ovf  = bus.ovf;
`endif
    in_fire  = iv && s_rdy;
    out_fire = s_ov && ordy;
    if (in_fire) exp_q.push_back(ref_add(ia, ib, ic));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.cin = 0; bus.out_ready = 0;
    bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0; bus8.out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else if (0) n_fail++;
    if (bus.out_valid !== 1'b0) n_fail++;
    n_tests++; if (bus.sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
    n_tests++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    rst_n = 1;
    @(posedge clk);
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_carry_chain();
    int nv, first;
    logic [W:0] got;
    nv = 0; first = -1; got = '0;
    exp_q.delete();
    cycle(1, 16'hFFFF, 16'h0001, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, '0, '0, 0, 1);
      if (s_ov) begin
        nv++;
        if (first < 0) first = i;
        got = {s_cout, s_sum};
      end
    end
    n_tests++; if (first !== 4) begin n_fail++; $display("FAIL carry_latency: got %0d want 4", first); end
    n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL carry_valid_cycles: got %0d want 1", nv); end
    n_tests++; if (got !== 17'h10000) begin n_fail++; $display("FAIL carry_result: got %h want 10000", got); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int nout, first, last;
    logic [W:0] e;
    nout = 0; first = -1; last = -1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (i < 8) cycle(1, 16'(i) * 16'h1111, 16'h0F0F, i[0], 1);
      else       cycle(0, '0, '0, 0, 1);
      if (out_fire) begin
        nout++;
        if (first < 0) first = i;
        last = i;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious: got %h want none", {s_cout, s_sum});
        end else begin
          e = exp_q.pop_front();
          if ({s_cout, s_sum} !== e) begin n_fail++; $display("FAIL b2b_result: got %h want %h", {s_cout, s_sum}, e); end
        end
      end
    end
    n_tests++; if (nout !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", nout); end
    n_tests++; if (last - first !== 7) begin n_fail++; $display("FAIL b2b_contiguous: got span %0d want 7", last - first); end
    n_tests++; if (first !== 4) begin n_fail++; $display("FAIL b2b_first_out: got %0d want 4", first); end
  endtask

  task automatic test_stall();
    int nout, first, last;
    logic [W:0] e;
    nout = 0; first = -1; last = -1;
    exp_q.delete();
    for (int i = 0; i < 4; i++)
      cycle(1, 16'($urandom), 16'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 16'h0F0F, 16'hF0F0, 1, 0);
      n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", s_rdy); end
      n_tests++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b want 1", s_ov); end
      n_tests++;
      if (exp_q.size() == 0 || {s_cout, s_sum} !== exp_q[0]) begin
        n_fail++; $display("FAIL stall_hold: got %h want %h", {s_cout, s_sum}, (exp_q.size() > 0) ? exp_q[0] : 17'h0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, '0, '0, 0, 1);
      if (out_fire) begin
        nout++;
        if (first < 0) first = i;
        last = i;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_spurious: got %h want none", {s_cout, s_sum});
        end else begin
          e = exp_q.pop_front();
          if ({s_cout, s_sum} !== e) begin n_fail++; $display("FAIL stall_drain: got %h want %h", {s_cout, s_sum}, e); end
        end
      end
    end
    n_tests++; if (nout !== 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", nout); end
    n_tests++; if (last - first !== 3) begin n_fail++; $display("FAIL stall_contiguous: got span %0d want 3", last - first); end
  endtask

  task automatic test_random();
    int accepted, cyc;
    logic [W-1:0] ra, rb;
    logic rc, riv, rordy, prev_stall;
    logic [W:0] e, prev_val;
    accepted = 0; cyc = 0; prev_stall = 0; prev_val = '0;
    exp_q.delete();
    while (accepted < 10000 && cyc < 60000) begin
      case ($urandom_range(0, 7))
        0:       begin ra = 16'h0FFF; rb = 16'h0001; rc = 0; end
        1:       begin ra = 16'h8000; rb = 16'h8000; rc = 0; end
        2:       begin ra = 16'hFFFF; rb = 16'h0000; rc = 1; end
        3:       begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1; end
        default: begin ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); end
      endcase
      riv   = 1'($urandom_range(0, 1));
      rordy = 1'($urandom_range(0, 1));
      cycle(riv, ra, rb, rc, rordy);
      cyc++;
      if (in_fire) accepted++;
      n_tests++;
      if (s_rdy !== (!s_ov || rordy)) begin n_fail++; $display("FAIL rand_in_ready: got %b want %b", s_rdy, !s_ov || rordy); end
      if (prev_stall) begin
        n_tests++;
        if (!s_ov || {s_cout, s_sum} !== prev_val) begin
          n_fail++; $display("FAIL rand_hold: got %b/%h want 1/%h", s_ov, {s_cout, s_sum}, prev_val);
        end
      end
      prev_stall = s_ov && !rordy;
      prev_val   = {s_cout, s_sum};
      if (out_fire) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: got %h want none", {s_cout, s_sum});
        end else begin
          e = exp_q.pop_front();
          if ({s_cout, s_sum} !== e) begin n_fail++; $display("FAIL rand_result: got %h want %h", {s_cout, s_sum}, e); end
        end
      end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      cycle(0, '0, '0, 0, 1);
      if (out_fire) begin
        n_tests++;
        e = exp_q.pop_front();
        if ({s_cout, s_sum} !== e) begin n_fail++; $display("FAIL rand_drain: got %h want %h", {s_cout, s_sum}, e); end
      end
    end
    n_tests++; if (accepted !== 10000) begin n_fail++; $display("FAIL rand_accepted: got %0d want 10000", accepted); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int first;
    logic [W:0] got;
    first = -1; got = '0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) cycle(1, 16'h1111 * 16'(i + 1), 16'h0101, 0, 0);
    cycle(0, '0, '0, 0, 0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
    rst_n = 0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.sum !== '0) begin n_fail++; $display("FAIL midrst_sum: got %h want 0", bus.sum); end
    n_tests++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL midrst_cout: got %b want 0", bus.cout); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cycle(1, 16'h1234, 16'h4321, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, '0, '0, 0, 1);
      if (s_ov && first < 0) begin first = i; got = {s_cout, s_sum}; end
    end
    n_tests++; if (first !== 4) begin n_fail++; $display("FAIL midrst_latency: got %0d want 4", first); end
    n_tests++; if (got !== 17'h05555) begin n_fail++; $display("FAIL midrst_result: got %h want 05555", got); end
    exp_q.delete();
  endtask

`ifdef RCA_PIPE_OVF_EN
  task automatic test_ovf();
    int nout;
    logic [W:0] e_val [2];
    logic       e_ovf [2];
    e_val[0] = 17'h08000; e_ovf[0] = 1'b1;
    e_val[1] = 17'h1FFFE; e_ovf[1] = 1'b0;
    nout = 0;
    exp_q.delete();
    cycle(1, 16'h7FFF, 16'h0001, 0, 1);
    cycle(1, 16'hFFFF, 16'hFFFF, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, '0, '0, 0, 1);
      if (out_fire && nout < 2) begin
        n_tests++; if ({s_cout, s_sum} !== e_val[nout]) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", {s_cout, s_sum}, e_val[nout]); end
        n_tests++; if (s_ovf !== e_ovf[nout]) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", s_ovf, e_ovf[nout]); end
        nout++;
      end
    end
    n_tests++; if (nout !== 2) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", nout); end
    exp_q.delete();
  endtask
`endif

  task automatic test_single_stage();
    logic [7:0] pa, pb;
    logic       pc;
    logic [8:0] e;
    bus8.out_ready = 1;
    bus8.in_valid = 1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 0;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    @(negedge clk);
    n_tests++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid: got %b want 1", bus8.out_valid); end
    n_tests++; if ({bus8.cout, bus8.sum} !== 9'h100) begin n_fail++; $display("FAIL s1_result: got %h want 100", {bus8.cout, bus8.sum}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL s1_valid_once: got %b want 0", bus8.out_valid); end
    @(posedge clk); #1;
    pa = '0; pb = '0; pc = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        bus8.in_valid = 1; bus8.a = 8'(i * 8'h11); bus8.b = 8'h0F; bus8.cin = i[0];
      end else begin
        bus8.in_valid = 0;
      end
      @(negedge clk);
      if (i > 0) begin
        e = ref_add8(pa, pb, pc);
        n_tests++;
        if (bus8.out_valid !== 1'b1 || {bus8.cout, bus8.sum} !== e) begin
          n_fail++; $display("FAIL s1_stream: got %b/%h want 1/%h", bus8.out_valid, {bus8.cout, bus8.sum}, e);
        end
      end
      pa = bus8.a; pb = bus8.b; pc = bus8.cin;
      @(posedge clk); #1;
    end
`ifdef RCA_PIPE_OVF_EN
    bus8.in_valid = 1; bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 0;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    @(negedge clk);
    n_tests++; if ({bus8.ovf, bus8.cout, bus8.sum} !== 10'b1_0_1000_0000) begin
      n_fail++; $display("FAIL s1_ovf: got %b/%b/%h want 1/0/80", bus8.ovf, bus8.cout, bus8.sum);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
`ifdef RCA_PIPE_OVF_EN
    test_ovf();
`endif
    test_single_stage();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
